// File: rtl/gun_pkg.sv
// Shared types and default constants for the light-gun sensor stage.
package gun_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_SCAN  = 3'd2,
    ST_HIT   = 3'd3,
    ST_MISS  = 3'd4,
    ST_HOLD  = 3'd5,
    ST_RLD   = 3'd6
  } gun_state_t;

  localparam logic [15:0] DEF_DEBOUNCE      = 16'd20000;
  localparam logic [7:0]  DEF_SENSOR_LEN    = 8'd12;
  localparam logic [7:0]  DEF_OFFS_LIM      = 8'd2;
  localparam logic [2:0]  DEF_RELOAD_FRAMES = 3'd5;

  // True when the beam position equals the captured aim point.
  function automatic logic aim_match(input logic [9:0] h, input logic [8:0] v,
                                     input logic [7:0] x, input logic [7:0] y);
    return (h == {2'b00, x}) && (v == {1'b0, y});
  endfunction

endpackage

// File: rtl/gun_debounce.sv
// Two-flop synchroniser followed by a restart-on-mismatch debounce counter.
module gun_debounce
  import gun_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic        sync1;
  logic        sync2;
  logic [15:0] cnt;

  // Synchronise the raw input and accept a new level after DEBOUNCE stable cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= 16'd0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != dout) begin
        if (cnt == DEBOUNCE - 16'd1) begin
          dout <= sync2;
          cnt  <= 16'd0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else begin
        cnt <= 16'd0;
      end
    end
  end

endmodule

// File: rtl/gun_sensor.sv
// Light-gun photo-sensor emulation: trigger debounce, shot FSM, reload strobe.
// Optional shot-coordinate latch compiled in with GUN_SENSOR_LATCH_EN.
module gun_sensor
  import gun_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE      = DEF_DEBOUNCE,
  parameter logic [7:0]  SENSOR_LEN    = DEF_SENSOR_LEN,
  parameter logic [7:0]  OFFS_LIM      = DEF_OFFS_LIM,
  parameter logic [2:0]  RELOAD_FRAMES = DEF_RELOAD_FRAMES
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE_PIX,
  input  logic       VDE,
  input  logic [9:0] H_COUNT,
  input  logic [8:0] V_COUNT,
  input  logic [7:0] GUN_X,
  input  logic [7:0] GUN_Y,
  input  logic       TRIGGER,
  output logic       TRIG_OUT,
  output logic       SENSOR,
  output logic       RELOAD,
  output logic [7:0] SHOT_X,
  output logic [7:0] SHOT_Y,
  output logic       SHOT_VALID,
  input  logic       SHOT_ACK
);

  gun_state_t state, state_nx;
  logic [7:0] tx, ty;
  logic [7:0] pcnt, pcnt_nx;
  logic [2:0] fcnt, fcnt_nx;
  logic       trig_prev, vde_prev;
  logic       capture;
  logic       trig_rise, vde_rise, vde_fall;

  gun_debounce #(.DEBOUNCE(DEBOUNCE)) u_trig_db (
    .clk  (CLK),
    .rst  (RESET),
    .din  (TRIGGER),
    .dout (TRIG_OUT)
  );

  // VDE edges are only meaningful on pixel ticks.
  assign trig_rise = TRIG_OUT & ~trig_prev;
  assign vde_rise  = CE_PIX & VDE & ~vde_prev;
  assign vde_fall  = CE_PIX & ~VDE & vde_prev;

  // Shot FSM next-state and counter logic.
  always_comb begin
    state_nx = state;
    pcnt_nx  = pcnt;
    fcnt_nx  = fcnt;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig_rise) begin
          if (GUN_Y < OFFS_LIM) begin
            state_nx = ST_RLD;
            fcnt_nx  = RELOAD_FRAMES;
          end else begin
            state_nx = ST_ARMED;
            capture  = 1'b1;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (vde_rise) state_nx = ST_SCAN;
        else          state_nx = ST_ARMED;
      end
      ST_SCAN: begin
        // A match on the tick where VDE falls still counts as a hit.
        if (CE_PIX && aim_match(H_COUNT, V_COUNT, tx, ty)) begin
          state_nx = ST_HIT;
          pcnt_nx  = SENSOR_LEN;
        end else if (vde_fall) begin
          state_nx = ST_MISS;
        end else begin
          state_nx = ST_SCAN;
        end
      end
      ST_HIT: begin
        if (CE_PIX) begin
          if (pcnt == 8'd1) begin
            state_nx = ST_HOLD;
            pcnt_nx  = 8'd0;
          end else begin
            pcnt_nx = pcnt - 8'd1;
          end
        end else begin
          pcnt_nx = pcnt;
        end
      end
      ST_MISS: state_nx = ST_HOLD;
      ST_HOLD: begin
        if (!TRIG_OUT) state_nx = ST_IDLE;
        else           state_nx = ST_HOLD;
      end
      ST_RLD: begin
        if (fcnt == 3'd0)  state_nx = ST_HOLD;
        else if (vde_rise) fcnt_nx  = fcnt - 3'd1;
        else               fcnt_nx  = fcnt;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, counters, edge history, aim capture and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      pcnt      <= 8'd0;
      fcnt      <= 3'd0;
      trig_prev <= 1'b0;
      vde_prev  <= 1'b0;
      tx        <= 8'd0;
      ty        <= 8'd0;
      SENSOR    <= 1'b0;
      RELOAD    <= 1'b0;
    end else begin
      state     <= state_nx;
      pcnt      <= pcnt_nx;
      fcnt      <= fcnt_nx;
      trig_prev <= TRIG_OUT;
      if (CE_PIX) vde_prev <= VDE;
      if (capture) begin
        tx <= GUN_X;
        ty <= GUN_Y;
      end
      SENSOR <= (state_nx == ST_HIT);
      RELOAD <= (state_nx == ST_RLD);
    end
  end

`ifdef GUN_SENSOR_LATCH_EN
  logic hit_entry;
  assign hit_entry = (state != ST_HIT) && (state_nx == ST_HIT);

  // Shot latch: a new hit takes priority over a simultaneous acknowledge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      SHOT_X     <= 8'd0;
      SHOT_Y     <= 8'd0;
      SHOT_VALID <= 1'b0;
    end else if (hit_entry) begin
      SHOT_X     <= tx;
      SHOT_Y     <= ty;
      SHOT_VALID <= 1'b1;
    end else if (SHOT_ACK) begin
      SHOT_VALID <= 1'b0;
    end
  end
`else
  logic unused_ack;
  assign unused_ack = SHOT_ACK;
  assign SHOT_X     = 8'd0;
  assign SHOT_Y     = 8'd0;
  assign SHOT_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_gun_sensor.sv
// Randomised bench for gun_sensor: traces every cycle and derives the expected
// SENSOR/RELOAD waveforms per shot from the raster timeline.
module tb_gun_sensor;

  localparam int D   = 4;
  localparam int LEN = 12;
  localparam int LIM = 2;
  localparam int RF  = 5;
  localparam int N   = 131072;

  logic       CLK = 1'b0;
  logic       RESET, CE_PIX, VDE, TRIGGER, SHOT_ACK;
  logic [9:0] H_COUNT;
  logic [8:0] V_COUNT;
  logic [7:0] GUN_X, GUN_Y;
  logic       TRIG_OUT, SENSOR, RELOAD, SHOT_VALID;
  logic [7:0] SHOT_X, SHOT_Y;

  always #5 CLK = ~CLK;

  gun_sensor #(.DEBOUNCE(16'd4)) dut (
    .CLK(CLK), .RESET(RESET), .CE_PIX(CE_PIX), .VDE(VDE),
    .H_COUNT(H_COUNT), .V_COUNT(V_COUNT), .GUN_X(GUN_X), .GUN_Y(GUN_Y),
    .TRIGGER(TRIGGER), .TRIG_OUT(TRIG_OUT), .SENSOR(SENSOR), .RELOAD(RELOAD),
    .SHOT_X(SHOT_X), .SHOT_Y(SHOT_Y), .SHOT_VALID(SHOT_VALID), .SHOT_ACK(SHOT_ACK)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // raster generator configuration
  int h_tot = 16, v_tot = 8, v_st = 2, v_en = 5;
  int hc = 0, vc = 0;
  bit ack_req = 1'b0, ack_at_tgt = 1'b0;
  int ack_x = 0, ack_y = 0;

  initial begin : raster
    CE_PIX = 1'b0; VDE = 1'b0; H_COUNT = 10'd0; V_COUNT = 9'd0; SHOT_ACK = 1'b0;
    forever begin
      @(posedge CLK);
      if (CE_PIX) begin
        hc++;
        if (hc >= h_tot) begin hc = 0; vc++; end
      end
      if (vc >= v_tot) vc = 0;
      #1;
      CE_PIX   = ($urandom_range(0, 7) != 0);
      H_COUNT  = 10'(hc);
      V_COUNT  = 9'(vc);
      VDE      = (vc >= v_st) && (vc <= v_en);
      SHOT_ACK = ack_req || (ack_at_tgt && CE_PIX && hc == ack_x && vc == ack_y);
    end
  end

  // per-cycle trace
  bit         tr_ce[N], tr_rise[N], tr_fall[N], tr_sen[N], tr_rld[N], tr_trg[N];
  logic [9:0] tr_h[N];
  logic [8:0] tr_v[N];
  logic [7:0] tr_gx[N], tr_gy[N];

  initial begin : monitor
    bit vp;
    vp = 1'b0;
    forever begin
      @(negedge CLK);
      if (cyc < N) begin
        tr_ce[cyc] = CE_PIX; tr_h[cyc] = H_COUNT; tr_v[cyc] = V_COUNT;
        tr_gx[cyc] = GUN_X;  tr_gy[cyc] = GUN_Y;
        tr_sen[cyc] = SENSOR; tr_rld[cyc] = RELOAD; tr_trg[cyc] = TRIG_OUT;
        if (RESET) begin
          tr_rise[cyc] = 1'b0; tr_fall[cyc] = 1'b0; vp = 1'b0;
        end else begin
          tr_rise[cyc] = CE_PIX && VDE && !vp;
          tr_fall[cyc] = CE_PIX && !VDE && vp;
          if (CE_PIX) vp = VDE;
        end
      end
    end
  end

  // Expected behaviour of one shot whose TRIG_OUT rise is seen in cycle t0.
  task automatic analyze(input int t0, input int t1, input string tag, output bit hit);
    int gx, gy, k, f, m, lo_s, hi_s, lo_r, hi_r, cnt, mis_s, mis_r, ticks;
    bit es, er;
    gx = int'(tr_gx[t0]); gy = int'(tr_gy[t0]);
    k = -1; f = -1; m = -1; lo_s = -1; hi_s = -2; lo_r = -1; hi_r = -2; hit = 1'b0;
    if (gy < LIM) begin
      lo_r = t0 + 1; cnt = 0;
      for (int n = t0 + 1; n <= t1; n++)
        if (tr_rise[n]) begin
          cnt++;
          if (cnt == RF) begin hi_r = n + 1; break; end
        end
      check_val({tag, "_frames"}, cnt, RF);
    end else begin
      for (int n = t0 + 1; n <= t1; n++) if (tr_rise[n]) begin k = n; break; end
      if (k >= 0)
        for (int n = k + 1; n <= t1; n++) begin
          if (tr_ce[n] && int'(tr_h[n]) == gx && int'(tr_v[n]) == gy) begin m = n; break; end
          if (tr_fall[n]) begin f = n; break; end
        end
      check_val({tag, "_scan_end"}, int'(m >= 0 || f >= 0), 1);
      if (m >= 0) begin
        hit = 1'b1; lo_s = m + 1; cnt = 0;
        for (int n = m + 1; n <= t1; n++)
          if (tr_ce[n]) begin
            cnt++;
            if (cnt == LEN) begin hi_s = n; break; end
          end
      end
    end
    mis_s = 0; mis_r = 0; ticks = 0;
    for (int n = t0 + 1; n <= t1; n++) begin
      es = (n >= lo_s) && (n <= hi_s);
      er = (n >= lo_r) && (n <= hi_r);
      if (tr_sen[n] != es) mis_s++;
      if (tr_rld[n] != er) mis_r++;
      if (tr_sen[n] && tr_ce[n]) ticks++;
    end
    check_val({tag, "_sensor_cycles_wrong"}, mis_s, 0);
    check_val({tag, "_reload_cycles_wrong"}, mis_r, 0);
    check_val({tag, "_sensor_ticks"}, ticks, hit ? LEN : 0);
  endtask

  task automatic shot(input int x, input int y, input bit repress, input int budget, output bit hit);
    int p, t0, nr, nf, n;
    bit seen, done;
    string tag;
    hit = 1'b0; t0 = 0;
    tag = $sformatf("shot_%0d_%0d", x, y);
    @(posedge CLK); #1;
    GUN_X = 8'(x); GUN_Y = 8'(y); TRIGGER = 1'b1; p = cyc;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (TRIG_OUT) begin seen = 1'b1; t0 = cyc; break; end
    end
    check_val({tag, "_trig_seen"}, int'(seen), 1);
    if (seen) begin
      check_val({tag, "_trig_latency"}, t0 - p, 2 + D);
      @(posedge CLK); #1;
      GUN_X = 8'($urandom); GUN_Y = 8'($urandom);
      repeat (2) @(posedge CLK);
      #1 TRIGGER = 1'b0;
      if (repress) begin
        repeat (12) @(posedge CLK);
        #1 TRIGGER = 1'b1;
        repeat (8) @(posedge CLK);
        #1 TRIGGER = 1'b0;
      end
      nr = 0; nf = 0; done = 1'b0; n = t0 + 1;
      for (int c = 0; c < budget && !done; c++) begin
        @(negedge CLK); #1;
        while (n <= cyc) begin
          nr += int'(tr_rise[n]); nf += int'(tr_fall[n]); n++;
        end
        done = (y < LIM) ? (nr >= RF) : (nf >= 2);
      end
      check_val({tag, "_settle"}, int'(done), 1);
      repeat (60) @(negedge CLK);
      #1 analyze(t0, cyc, tag, hit);
      for (int c = 0; c < 40 && TRIG_OUT; c++) @(negedge CLK);
    end
  endtask

  initial begin : main
    bit hit;
    int t, cnt_t, cnt_s;
    RESET = 1'b1; TRIGGER = 1'b0; GUN_X = 8'd0; GUN_Y = 8'd0;
    repeat (4) @(negedge CLK);
    check_val("rst_trig_out", TRIG_OUT, 0);
    check_val("rst_sensor", SENSOR, 0);
    check_val("rst_reload", RELOAD, 0);
    check_val("rst_shot_x", SHOT_X, 0);
    check_val("rst_shot_y", SHOT_Y, 0);
    check_val("rst_shot_valid", SHOT_VALID, 0);
    @(posedge CLK); #3 RESET = 1'b0;

    // full-size raster: hit at (100,80), re-press during the scan is ignored
    h_tot = 104; v_tot = 84; v_st = 16; v_en = 81;
    repeat (20) @(posedge CLK);
    shot(100, 80, 1'b1, 30000, hit);
`ifdef GUN_SENSOR_LATCH_EN
    check_val("latch1_x", SHOT_X, 100);
    check_val("latch1_y", SHOT_Y, 80);
    check_val("latch1_valid", SHOT_VALID, 1);
`else
    check_val("nolatch_valid", SHOT_VALID, 0);
`endif
    // second hit with ACK in the same cycle as the hit tick
    @(negedge CLK); ack_x = 50; ack_y = 60; ack_at_tgt = 1'b1;
    shot(50, 60, 1'b0, 30000, hit);
    @(negedge CLK); ack_at_tgt = 1'b0;
`ifdef GUN_SENSOR_LATCH_EN
    check_val("latch2_valid", SHOT_VALID, 1);
    check_val("latch2_x", SHOT_X, 50);
    check_val("latch2_y", SHOT_Y, 60);
    @(negedge CLK); ack_req = 1'b1;
    @(negedge CLK); ack_req = 1'b0;
    @(negedge CLK);
    check_val("latch_ack_clears", SHOT_VALID, 0);
    check_val("latch_ack_keeps_x", SHOT_X, 50);
`else
    check_val("nolatch_x", SHOT_X, 0);
    check_val("nolatch_valid2", SHOT_VALID, 0);
`endif

    // small raster for the remaining tests
    h_tot = 16; v_tot = 8; v_st = 2; v_en = 5;
    repeat (40) @(posedge CLK);

    // bounce: toggles every 2 CLK never pass the debouncer
    @(negedge CLK); t = cyc;
    @(posedge CLK); #1;
    for (int i = 0; i < 15; i++) begin
      TRIGGER = ~TRIGGER;
      repeat (2) @(posedge CLK);
      #1;
    end
    TRIGGER = 1'b0;
    repeat (30) @(negedge CLK);
    cnt_t = 0; cnt_s = 0;
    for (int n = t; n <= cyc; n++) begin cnt_t += int'(tr_trg[n]); cnt_s += int'(tr_sen[n]); end
    check_val("bounce_trig_out_cycles", cnt_t, 0);
    check_val("bounce_sensor_cycles", cnt_s, 0);

    // directed boundaries: fall-tick match, last visible pixel, Y limit, off-screen, miss
    shot(8, 3, 1'b0, 3000, hit);
    shot(0, 6, 1'b0, 3000, hit);
    shot(15, 5, 1'b0, 3000, hit);
    shot(3, 2, 1'b0, 3000, hit);
    shot(4, 1, 1'b0, 3000, hit);
    shot(7, 250, 1'b0, 3000, hit);
    shot(9, 0, 1'b0, 3000, hit);

    // reset in the middle of a sensor pulse
    @(posedge CLK); #1;
    GUN_X = 8'd8; GUN_Y = 8'd4; TRIGGER = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge CLK);
      hit = SENSOR;
    end
    check_val("rst_test_pulse_seen", int'(hit), 1);
    @(posedge CLK); #3 RESET = 1'b1;
    #1;
    check_val("rst_mid_sensor", SENSOR, 0);
    check_val("rst_mid_reload", RELOAD, 0);
    check_val("rst_mid_trig_out", TRIG_OUT, 0);
    check_val("rst_mid_valid", SHOT_VALID, 0);
    TRIGGER = 1'b0;
    repeat (3) @(posedge CLK);
    #3 RESET = 1'b0;
    @(negedge CLK); t = cyc;
    repeat (400) @(negedge CLK);
    cnt_s = 0;
    for (int n = t; n <= cyc; n++) cnt_s += int'(tr_sen[n]) + int'(tr_rld[n]);
    check_val("post_rst_no_pulse", cnt_s, 0);

    // randomised shots over the small raster
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(1, 60)) @(posedge CLK);
      shot($urandom_range(0, 17), $urandom_range(0, 9), 1'b0, 3000, hit);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gun_sensor.md
# gun_sensor

Light-gun sensor and trigger emulation stage downstream of the virtual-gun crosshair generator. It takes the gun's aim position (X/Y), the raster counters (H/V count) and the raw trigger button. It produces the photo-sensor pulse the game CPU expects when the beam passes the aimed pixel, a debounced trigger line and an off-screen reload strobe. An optional latch captures the shot coordinates behind a valid/ack handshake for the CPU input port.

## Interface
- DEBOUNCE, 16'd20000: CLK cycles the trigger must be stable before a level change is accepted.
- SENSOR_LEN, 8'd12: sensor pulse length in CE_PIX ticks.
- OFFS_LIM, 8'd2: aim Y below this value counts as off-screen.
- RELOAD_FRAMES, 3'd5: frames RELOAD stays high after an off-screen shot.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- CE_PIX  in  1  pixel clock enable.
- VDE  in  1  vertical display enable.
- H_COUNT  in  10  raster pixel counter.
- V_COUNT  in  9  raster line counter.
- GUN_X  in  8  aim X (gun X_OUT).
- GUN_Y  in  8  aim Y (gun Y_OUT).
- TRIGGER  in  1  raw, asynchronous button, active-high.
- TRIG_OUT  out  1  debounced trigger level.
- SENSOR  out  1  photo-sensor pulse.
- RELOAD  out  1  reload indication.
- SHOT_X  out  8  latched shot X.
- SHOT_Y  out  8  latched shot Y.
- SHOT_VALID  out  1  latched coordinates pending.
- SHOT_ACK  in  1  consumer acknowledge, single CLK.

## Operation
- TRIGGER passes through a 2-flop synchroniser, then a debounce counter.
  - The counter restarts on every mismatch between the synchronised input and TRIG_OUT.
  - TRIG_OUT toggles when the counter reaches DEBOUNCE-1.
- Shot FSM states: IDLE, ARMED, SCAN, HIT, MISS, HOLD, RLD.
  - IDLE: on a TRIG_OUT rising edge, go to RLD if GUN_Y < OFFS_LIM, else go to ARMED and capture GUN_X/GUN_Y into internal tx/ty.
  - ARMED: on the VDE rising edge (sampled on CE_PIX), go to SCAN.
  - SCAN: on a CE_PIX tick where H_COUNT == {2'b0,tx} and V_COUNT == {1'b0,ty}, go to HIT and load the pulse counter with SENSOR_LEN. If VDE falls first, go to MISS.
  - HIT: SENSOR=1. Decrement the counter per CE_PIX; at 1, go to HOLD.
  - MISS: one CLK, then HOLD. SENSOR stays 0.
  - HOLD: wait for TRIG_OUT=0, then go to IDLE.
  - RLD: RELOAD=1. Decrement the frame counter (loaded with RELOAD_FRAMES) on each VDE rising edge. At 0, go to HOLD.
- A trigger press in any state other than IDLE is ignored. No queuing.
- Aim changes after capture do not affect the SCAN target.

## Timing
- RESET values: FSM=IDLE, TRIG_OUT=0, SENSOR=0, RELOAD=0, SHOT_X=0, SHOT_Y=0, SHOT_VALID=0, all counters 0.
- Outputs are registered. SENSOR rises one CLK after the matching CE_PIX tick and lasts exactly SENSOR_LEN CE_PIX ticks.
- Press latency: synchroniser 2 CLK + DEBOUNCE CLK to TRIG_OUT, then 1 CLK to leave IDLE.
- A match on the last visible pixel before VDE falls on the same tick counts as a HIT (the match check has priority).
- If VDE is already high when ARMED is entered, wait for the next rising edge. A full frame is always scanned.
- RELOAD is high from RLD entry through the CLK in which the counter reaches 0.
- RESET mid-pulse drops SENSOR and RELOAD asynchronously. No pulse resumes after reset.

## Configuration
- GUN_SENSOR_LATCH_EN defined (shot latch compiled in):
  - On HIT entry, SHOT_X/SHOT_Y load tx/ty and SHOT_VALID sets.
  - SHOT_ACK clears SHOT_VALID on the next CLK.
  - A HIT while SHOT_VALID=1 overwrites the coordinates and keeps VALID set.
  - If SHOT_ACK and a new HIT fall in the same CLK, the HIT wins: VALID stays 1.
- GUN_SENSOR_LATCH_EN undefined: SHOT_X, SHOT_Y and SHOT_VALID are tied to 0, SHOT_ACK is ignored, and no latch registers exist.

## Structure
- Package gun_pkg holds:
  - the state enum gun_state_t;
  - default constants for debounce, pulse length and reload frames.
- Sub-module gun_debounce: synchroniser plus counter, parameterised by DEBOUNCE. Instantiated once for TRIGGER.
- The FSM, edge detect and latch stay in gun_sensor.

## Test plan
- Hit: DEBOUNCE=4, GUN_X=100, GUN_Y=80, press → SENSOR high exactly 12 CE_PIX ticks, starting one CLK after H_COUNT=100, V_COUNT=80 in the next frame.
- Bounce: toggle TRIGGER every 2 CLK for 30 CLK, then release → TRIG_OUT stays 0 and no SENSOR.
- Off-screen: GUN_Y=1, press → RELOAD high for 5 VDE rising edges, SENSOR never asserted.
- Miss: GUN_Y=250 with active lines 16..239 → MISS, SENSOR stays 0, FSM returns to IDLE after release.
- Latch (GUN_SENSOR_LATCH_EN): hit at (100,80) → SHOT_X=100, SHOT_Y=80, SHOT_VALID=1; with SHOT_ACK asserted in the same CLK as a second HIT at (50,60) → VALID stays 1 and SHOT_X=50.
- Reset: assert RESET during HIT → SENSOR drops immediately. After release, no pulse until a new press.
